// File: rtl/md_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
package md_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    FIX,
    DONE
  } md_state_e;

  localparam logic        OP_MUL       = 1'b0;
  localparam logic        OP_DIV       = 1'b1;
  localparam int unsigned OP_UNSIGNED  = 1;
  localparam int unsigned MD_DEF_WIDTH = 32;

  function automatic int unsigned md_cnt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/md_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, restore on borrow.
module md_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic [1:0]       unused_bits;

  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, div_i};
    if (diff[WIDTH+1]) begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

  // Top bits are provably zero whenever the corresponding value is selected.
  assign unused_bits = {shifted[WIDTH], diff[WIDTH]};

endmodule

// File: rtl/md_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring on magnitudes) unit.
// Optional build macro MD_UNSIGNED_EN: op[1] selects unsigned MUL/DIV.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = MD_DEF_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_by_zero
);

  localparam int unsigned     CntW    = md_cnt_w(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

`ifdef MD_UNSIGNED_EN
  localparam logic UnsEn = 1'b1;
`else
  localparam logic UnsEn = 1'b0;
`endif

  md_state_e       state_q, state_d;
  logic            div_q, div_d;
  logic            uns_q, uns_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic            qm1_q, qm1_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            dbz_q, dbz_d;

  logic            a_neg, b_neg, accept, shift_in;
  logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix, div_rem, div_quo;
  logic [WIDTH:0]   booth_sum;

  // Accumulator holds the remainder during DIV; q holds the quotient, m the divisor magnitude.
  md_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (acc_q[WIDTH-1:0]),
    .quo_i (q_q),
    .div_i (m_q[WIDTH-1:0]),
    .rem_o (div_rem),
    .quo_o (div_quo)
  );

  always_comb begin
    a_neg   = a_q[WIDTH-1] & ~uns_q;
    b_neg   = b_q[WIDTH-1] & ~uns_q;
    a_mag   = a_neg ? -a_q : a_q;
    b_mag   = b_neg ? -b_q : b_q;
    quo_fix = (a_neg ^ b_neg) ? -q_q : q_q;
    rem_fix = a_neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    // Unsigned multiply degenerates to shift-add with a zero shifted into the accumulator.
    if (uns_q) begin
      booth_sum = q_q[0] ? acc_q + m_q : acc_q;
      shift_in  = 1'b0;
    end else begin
      unique case ({q_q[0], qm1_q})
        2'b01:   booth_sum = acc_q + m_q;
        2'b10:   booth_sum = acc_q - m_q;
        default: booth_sum = acc_q;
      endcase
      shift_in = booth_sum[WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    uns_d   = uns_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;

    unique case (state_q)
      IDLE: accept = start;
      LOAD: begin
        busy  = 1'b1;
        cnt_d = '0;
        acc_d = '0;
        qm1_d = 1'b0;
        if (div_q == OP_DIV) begin
          q_d = a_mag;
          m_d = {1'b0, b_mag};
        end else begin
          q_d = b_q;
          m_d = {~uns_q & a_q[WIDTH-1], a_q};
        end
        state_d = ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (div_q == OP_DIV) begin
          acc_d = {1'b0, div_rem};
          q_d   = div_quo;
        end else begin
          acc_d = {shift_in, booth_sum[WIDTH:1]};
          q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
          qm1_d = q_q[0];
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = FIX;
      end
      FIX: begin
        busy = 1'b1;
        if (div_q == OP_DIV) begin
          if (b_q == '0) begin
            hi_d  = a_q;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end else begin
          hi_d = acc_q[WIDTH-1:0];
          lo_d = q_q;
        end
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        accept  = start;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = LOAD;
      div_d   = (op[0] == OP_DIV);
      uns_d   = op[OP_UNSIGNED] & UnsEn;
      a_d     = a;
      b_d     = b;
      dbz_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      div_q   <= 1'b0;
      uns_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      uns_q   <= uns_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (WIDTH=32).
module tb_md_unit;

  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         clear, start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi_out, lo_out;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  md_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .div_by_zero (div_by_zero)
  );

  // Called #1 after an edge with the unit idle; returns edges from accept to done.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    @(posedge clock); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if (hi_out !== 32'h0) begin bad++; $display("FAIL rst_hi: got %h want 0", hi_out); end
    total++; if (lo_out !== 32'h0) begin bad++; $display("FAIL rst_lo: got %h want 0", lo_out); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL rst_dbz: got %b want 0", div_by_zero); end
    clear = 1'b1;
    @(posedge clock); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_mul();
    int lat;
    run_op(2'b00, 32'd7, 32'hFFFF_FFFD, lat);
    total++; if (lat != 34) begin bad++; $display("FAIL mul_latency: got %0d want 34", lat); end
    total++; if (hi_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mul_hi: got %h want ffffffff", hi_out); end
    total++; if (lo_out !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mul_lo: got %h want ffffffeb", lo_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mul_busy_done: got %b want 0", busy); end
    @(posedge clock); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mul_done_pulse: got %b want 0", done); end
    total++; if (lo_out !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mul_lo_held: got %h want ffffffeb", lo_out); end
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, lat);
    total++; if (hi_out !== 32'h4000_0000) begin bad++; $display("FAIL mul_min_hi: got %h want 40000000", hi_out); end
    total++; if (lo_out !== 32'h0) begin bad++; $display("FAIL mul_min_lo: got %h want 0", lo_out); end
    @(posedge clock); #1;
  endtask

  task automatic test_div_signed();
    int lat;
    run_op(2'b01, 32'hFFFF_FFF9, 32'd2, lat);
    total++; if (lat != 34) begin bad++; $display("FAIL div_latency: got %0d want 34", lat); end
    total++; if (lo_out !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_quo: got %h want fffffffd", lo_out); end
    total++; if (hi_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_rem: got %h want ffffffff", hi_out); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL div_dbz: got %b want 0", div_by_zero); end
    run_op(2'b01, 32'd7, 32'hFFFF_FFFE, lat);
    total++; if (lo_out !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_negb_quo: got %h want fffffffd", lo_out); end
    total++; if (hi_out !== 32'd1) begin bad++; $display("FAIL div_negb_rem: got %h want 1", hi_out); end
    run_op(2'b01, 32'd100, 32'd7, lat);
    total++; if (lo_out !== 32'd14) begin bad++; $display("FAIL div_pos_quo: got %h want e", lo_out); end
    total++; if (hi_out !== 32'd2) begin bad++; $display("FAIL div_pos_rem: got %h want 2", hi_out); end
    @(posedge clock); #1;
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(2'b01, 32'd5, 32'd0, lat);
    total++; if (lat != 34) begin bad++; $display("FAIL dbz_latency: got %0d want 34", lat); end
    total++; if (lo_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dbz_quo: got %h want ffffffff", lo_out); end
    total++; if (hi_out !== 32'd5) begin bad++; $display("FAIL dbz_rem: got %h want 5", hi_out); end
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag: got %b want 1", div_by_zero); end
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    total++; if (lo_out !== 32'h8000_0000) begin bad++; $display("FAIL ovf_quo: got %h want 80000000", lo_out); end
    total++; if (hi_out !== 32'h0) begin bad++; $display("FAIL ovf_rem: got %h want 0", hi_out); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL ovf_dbz: got %b want 0", div_by_zero); end
    @(posedge clock); #1;
  endtask

  task automatic test_ignore_and_reset();
    int  lat;
    logic seen;
    op = 2'b00; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; lat = 0;
    repeat (4) begin @(posedge clock); #1; lat++; end
    a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clock); #1; lat++;
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ign_busy: got %b want 1", busy); end
    while (done !== 1'b1 && lat < 100) begin @(posedge clock); #1; lat++; end
    total++; if (lat != 34) begin bad++; $display("FAIL ign_latency: got %0d want 34", lat); end
    total++; if (hi_out !== 32'h0) begin bad++; $display("FAIL ign_hi: got %h want 0", hi_out); end
    total++; if (lo_out !== 32'd12) begin bad++; $display("FAIL ign_lo: got %h want c", lo_out); end
    // Third operation aborted by reset mid-flight.
    a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1 clear = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    total++; if (hi_out !== 32'h0) begin bad++; $display("FAIL abort_hi: got %h want 0", hi_out); end
    total++; if (lo_out !== 32'h0) begin bad++; $display("FAIL abort_lo: got %h want 0", lo_out); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL abort_dbz: got %b want 0", div_by_zero); end
    @(posedge clock); #1;
    clear = 1'b1;
    seen = 1'b0;
    repeat (50) begin
      @(posedge clock); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_done: got %b want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int   lat;
    logic held_ok;
    run_op(2'b00, 32'd2, 32'd3, lat);
    total++; if (lo_out !== 32'd6) begin bad++; $display("FAIL b2b_first_lo: got %h want 6", lo_out); end
    op = 2'b00; a = 32'd5; b = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_busy: got %b want 1", busy); end
    held_ok = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      @(posedge clock); #1;
      if (hi_out !== 32'h0 || lo_out !== 32'd6 || done !== 1'b0 || busy !== 1'b1) held_ok = 1'b0;
    end
    total++; if (held_ok !== 1'b1) begin bad++; $display("FAIL b2b_held: got %b want 1", held_ok); end
    @(posedge clock); #1;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done: got %b want 1", done); end
    total++; if (lo_out !== 32'd35) begin bad++; $display("FAIL b2b_second_lo: got %h want 23", lo_out); end
    @(posedge clock); #1;
  endtask

  task automatic test_unsigned();
    int         lat;
    logic [W-1:0] exp_hi;
`ifdef MD_UNSIGNED_EN
    exp_hi = 32'd1;
`else
    exp_hi = 32'hFFFF_FFFF;
`endif
    run_op(2'b10, 32'hFFFF_FFFF, 32'd2, lat);
    total++; if (hi_out !== exp_hi) begin bad++; $display("FAIL uns_hi: got %h want %h", hi_out, exp_hi); end
    total++; if (lo_out !== 32'hFFFF_FFFE) begin bad++; $display("FAIL uns_lo: got %h want fffffffe", lo_out); end
    total++; if (lat != 34) begin bad++; $display("FAIL uns_latency: got %0d want 34", lat); end
    @(posedge clock); #1;
  endtask

  initial begin
    clear = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    test_reset();
    test_mul();
    test_div_signed();
    test_div_zero();
    test_ignore_and_reset();
    test_back_to_back();
    test_unsigned();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
